motion_alarm_ctrl: RTL and testbench

//  Motion-detection alarm controller; the DUT driven by the bench stimulus module.

---
 rtl/motion_alarm_ctrl_pkg.sv | 18 +
 rtl/motion_alarm_ctrl_pir_sync_edge.sv | 38 +++
 rtl/motion_alarm_ctrl.sv | 151 +++++++++++++++
 tb/tb_motion_alarm_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_alarm_ctrl_pkg.sv
// Shared definitions for the motion alarm controller: the state encoding,
// the zone width and a small elaboration-time helper.
package motion_alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ALARM   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam int ZONE_W = 3;

    // Larger of two integers, used to size the shared ALARM/HOLDOFF timer.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/motion_alarm_ctrl_pir_sync_edge.sv
// W-bit two-flop synchronizer followed by a delay flop for rising-edge
// detection. A line that is already high when reset is released still
// produces one rise, because the delay flop comes out of reset at 0.
module pir_sync_edge #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1_q, s2_q, s3_q;
    logic [W-1:0] s1_d, s2_d, s3_d;

    // Next values of the synchronizer chain and the edge-detect delay flop.
    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Chain registers; asynchronous clear puts every stage at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/motion_alarm_ctrl.sv
// Motion-detection alarm controller. Synchronized PIR rises arm a latched
// alarm that runs for ALARM_CYCLES cycles (or until stop_alarm), then a
// HOLDOFF window blinds the sensors before returning to IDLE.
// All outputs are registered; dbg_state mirrors the FSM state register.
module motion_alarm_ctrl
    import motion_alarm_ctrl_pkg::*;
#(
    parameter int ALARM_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 8,
    parameter int BUZZ_DIV       = 2,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stop_alarm,
    input  logic              pir_sensor_1,
    input  logic              pir_sensor_2,
    input  logic              pir_sensor_3,
    output logic              alarm,
    output logic              buzzer,
    output logic [ZONE_W-1:0] zone,
    output logic [CNT_W-1:0]  event_count,
    output logic [1:0]        dbg_state
);

    localparam int TMR_W = $clog2(max2(ALARM_CYCLES, HOLDOFF_CYCLES)) + 1;
    localparam int DIV_W = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

    localparam logic [TMR_W-1:0] ALARM_LOAD = TMR_W'(ALARM_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(HOLDOFF_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BUZZ_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [ZONE_W-1:0] rise;
    logic              stop_s1_q, stop_s2_q;
    logic              stop_s;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              buzzer_q, buzzer_d;
    logic              alarm_q, alarm_d;
    logic [ZONE_W-1:0] zone_q, zone_d;
    logic [CNT_W-1:0]  count_q, count_d;

    pir_sync_edge #(.W(ZONE_W)) u_pir_sync (
        .clk  (clk),
        .rst  (reset),
        .din  ({pir_sensor_3, pir_sensor_2, pir_sensor_1}),
        .rise (rise)
    );

    // Plain two-flop synchronizer for the stop button level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stop_s1_q <= 1'b0;
            stop_s2_q <= 1'b0;
        end else begin
            stop_s1_q <= stop_alarm;
            stop_s2_q <= stop_s1_q;
        end
    end

    assign stop_s = stop_s2_q;

    // Next-state and next-output logic for the FSM, timer, divider, zone and counter.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        div_d    = div_q;
        buzzer_d = buzzer_q;
        alarm_d  = alarm_q;
        zone_d   = zone_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                // A held stop button blinds the sensors; zone keeps the last alarm's map.
                if ((|rise) && !stop_s) begin
                    state_d  = ST_ALARM;
                    alarm_d  = 1'b1;
                    zone_d   = rise;
                    timer_d  = ALARM_LOAD;
                    buzzer_d = 1'b1;
                    div_d    = '0;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_ALARM: begin
                // Late sensors join the zone map but neither restart the timer nor count.
                zone_d = zone_q | rise;
                if (stop_s || (timer_q == '0)) begin
                    state_d  = ST_HOLDOFF;
                    alarm_d  = 1'b0;
                    buzzer_d = 1'b0;
                    div_d    = '0;
                    timer_d  = HOLD_LOAD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                    if (div_q == DIV_LAST) begin
                        buzzer_d = ~buzzer_q;
                        div_d    = '0;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            ST_HOLDOFF: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                alarm_d  = 1'b0;
                buzzer_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs; reset drops everything without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            div_q    <= '0;
            buzzer_q <= 1'b0;
            alarm_q  <= 1'b0;
            zone_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            div_q    <= div_d;
            buzzer_q <= buzzer_d;
            alarm_q  <= alarm_d;
            zone_q   <= zone_d;
            count_q  <= count_d;
        end
    end

    assign alarm       = alarm_q;
    assign buzzer      = buzzer_q;
    assign zone        = zone_q;
    assign event_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_motion_alarm_ctrl.sv
// Bench for motion_alarm_ctrl: directed scenarios plus a random phase, all
// scored cycle by cycle against a behavioural model of the alarm rules.
module tb_motion_alarm_ctrl;

    localparam int ALARM_CYCLES   = 16;
    localparam int HOLDOFF_CYCLES = 8;
    localparam int BUZZ_DIV       = 2;
    localparam int CNT_W          = 8;
    localparam int CNT_MAX        = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             stop_alarm;
    logic             pir_sensor_1, pir_sensor_2, pir_sensor_3;
    logic             alarm, buzzer;
    logic [2:0]       zone;
    logic [CNT_W-1:0] event_count;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected {state, alarm, buzzer, zone, count} after each rising edge.
    logic [14:0] exp_q[$];

    motion_alarm_ctrl #(
        .ALARM_CYCLES   (ALARM_CYCLES),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
        .BUZZ_DIV       (BUZZ_DIV),
        .CNT_W          (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stop_alarm   (stop_alarm),
        .pir_sensor_1 (pir_sensor_1),
        .pir_sensor_2 (pir_sensor_2),
        .pir_sensor_3 (pir_sensor_3),
        .alarm        (alarm),
        .buzzer       (buzzer),
        .zone         (zone),
        .event_count  (event_count),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 alarm, 2 holdoff. a_elapsed counts cycles already spent
    // alarming, h_elapsed cycles already spent in holdoff.
    int         m_mode;
    int         m_a_elapsed;
    int         m_h_elapsed;
    int         m_count;
    logic [2:0] m_zone;
    logic [2:0] pir_hist[3];   // samples taken 1, 2 and 3 edges ago
    logic       stop_hist[2];  // stop samples taken 1 and 2 edges ago

    function automatic logic [14:0] model_out();
        logic [1:0] st;
        logic       a, b;
        st = m_mode[1:0];
        a  = (m_mode == 1);
        b  = a && (((m_a_elapsed / BUZZ_DIV) % 2) == 0);
        return {st, a, b, m_zone, m_count[7:0]};
    endfunction

    task automatic model_step();
        logic [2:0] rise;
        logic       stp;
        if (reset) begin
            m_mode = 0; m_a_elapsed = 0; m_h_elapsed = 0; m_count = 0; m_zone = 3'b000;
            for (int i = 0; i < 3; i++) pir_hist[i] = 3'b000;
            for (int i = 0; i < 2; i++) stop_hist[i] = 1'b0;
        end else begin
            // A rise is a sample seen two edges ago that was low the edge before.
            rise = pir_hist[1] & ~pir_hist[2];
            stp  = stop_hist[1];
            pir_hist[2]  = pir_hist[1];
            pir_hist[1]  = pir_hist[0];
            pir_hist[0]  = {pir_sensor_3, pir_sensor_2, pir_sensor_1};
            stop_hist[1] = stop_hist[0];
            stop_hist[0] = stop_alarm;
            if (m_mode == 0) begin
                if (rise != 3'b000 && !stp) begin
                    m_mode = 1; m_a_elapsed = 0; m_zone = rise;
                    if (m_count < CNT_MAX) m_count = m_count + 1;
                end
            end else if (m_mode == 1) begin
                m_zone = m_zone | rise;
                if (stp || m_a_elapsed == ALARM_CYCLES - 1) begin
                    m_mode = 2; m_h_elapsed = 0;
                end else begin
                    m_a_elapsed = m_a_elapsed + 1;
                end
            end else begin
                if (m_h_elapsed == HOLDOFF_CYCLES - 1) m_mode = 0;
                else m_h_elapsed = m_h_elapsed + 1;
            end
        end
        exp_q.push_back(model_out());
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- scoreboard monitor ----------------
    initial forever begin
        logic [14:0] e, got;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {dbg_state, alarm, buzzer, zone, event_count};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got st=%0d al=%b bz=%b zone=%b cnt=%0d exp st=%0d al=%b bz=%b zone=%b cnt=%0d",
                         $time, got[14:13], got[12], got[11], got[10:8], got[7:0],
                         e[14:13], e[12], e[11], e[10:8], e[7:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pir(input logic [2:0] v);
        {pir_sensor_3, pir_sensor_2, pir_sensor_1} = v;
    endtask

    task automatic pulse(input logic [2:0] v, input int len);
        set_pir(v);
        idle(len);
        set_pir(3'b000);
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog simulation time limit reached");
        finish_run();
    end

    // ---------------- stimulus ----------------
    initial begin
        int hi;
        int stop_left;
        reset = 1'b1; stop_alarm = 1'b0; set_pir(3'b000);
        idle(3);
        check("reset_alarm", alarm, 0);
        check("reset_count", event_count, 0);
        reset = 1'b0;
        idle(3);

        // 1: single-period pulse on sensor 1, latency and duration.
        @(negedge clk); set_pir(3'b001);
        @(posedge clk); #1 check("t1_after_k", alarm, 0);
        @(negedge clk); set_pir(3'b000);
        @(posedge clk); #1 check("t1_after_k1", alarm, 0);
        @(posedge clk); #1 check("t1_after_k2", alarm, 1);
        check("t1_zone", zone, 1);
        check("t1_count", event_count, 1);
        hi = 1;
        repeat (20) begin
            @(posedge clk); #1 if (alarm) hi++;
        end
        check("t1_duration", hi, ALARM_CYCLES);
        idle(12);

        // 2: stop after 5 alarm cycles, then a sensor 2 pulse inside HOLDOFF.
        pulse(3'b001, 1);
        idle(2 + 5);
        stop_alarm = 1'b1; idle(2); stop_alarm = 1'b0;
        idle(4);
        pulse(3'b010, 1);
        idle(20);

        // 3: sensors 2 and 3 together, sensor 1 joins mid-alarm.
        pulse(3'b110, 1);
        idle(8);
        pulse(3'b001, 1);
        idle(30);

        // 4: stop held in IDLE blinds the sensors; after release a pulse alarms.
        stop_alarm = 1'b1; idle(3);
        pulse(3'b100, 2);
        idle(4);
        stop_alarm = 1'b0; idle(4);
        pulse(3'b100, 1);
        idle(30);

        // 5: a sensor held high for 100 cycles gives one event only.
        set_pir(3'b010); idle(100); set_pir(3'b000);
        idle(30);

        // Random phase: slow random sensor toggling and occasional stop presses.
        stop_left = 0;
        repeat (1500) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) pir_sensor_1 = ~pir_sensor_1;
            if ($urandom_range(0, 15) == 0) pir_sensor_2 = ~pir_sensor_2;
            if ($urandom_range(0, 15) == 0) pir_sensor_3 = ~pir_sensor_3;
            if (stop_left > 0) begin
                stop_left--;
                stop_alarm = (stop_left > 0);
            end else if ($urandom_range(0, 40) == 0) begin
                stop_left  = $urandom_range(1, 4);
                stop_alarm = 1'b1;
            end
        end
        set_pir(3'b000); stop_alarm = 1'b0;
        idle(40);

        // Counter saturation: many short alarms, each cut short by stop.
        repeat (300) begin
            pulse(3'($urandom_range(1, 7)), 1);
            idle(3);
            stop_alarm = 1'b1; idle(1); stop_alarm = 1'b0;
            idle(13);
        end
        idle(20);
        check("count_saturated", event_count, CNT_MAX);

        // 6: reset mid-alarm clears outputs at once; a sensor held through release re-arms.
        pulse(3'b001, 1);
        idle(6);
        #2 reset = 1'b1;
        #1;
        check("rst_alarm", alarm, 0);
        check("rst_buzzer", buzzer, 0);
        check("rst_zone", zone, 0);
        check("rst_count", event_count, 0);
        set_pir(3'b010);
        idle(3);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("rel_after_2", alarm, 0);
        @(posedge clk);
        #1 check("rel_after_3", alarm, 1);
        check("rel_zone", zone, 2);
        check("rel_count", event_count, 1);
        idle(10);
        set_pir(3'b000);
        idle(30);

        finish_run();
    end

endmodule
